disp_sched: RTL



---
 rtl/disp_sched_pkg.sv | 24 ++
 rtl/disp_oitf.sv | 82 ++++++++
 rtl/disp_sched.sv | 75 +++++++
 3 files changed

// File: rtl/disp_sched_pkg.sv
// Shared definitions for the dispatch scheduler: register index width, OITF defaults,
// OITF entry layout and the per-entry hazard match helper.
`ifndef MYRISCV_REGADDRBUS
`define MYRISCV_REGADDRBUS 5
`endif

package disp_sched_pkg;

  localparam int RIDX_W_DEF     = `MYRISCV_REGADDRBUS;
  localparam int OITF_DEPTH_DEF = 4;
  localparam int ITAG_W_DEF     = 2;

  typedef struct packed {
    logic                  vld;
    logic                  rdwen;
    logic [RIDX_W_DEF-1:0] rdidx;
  } oitf_entry_t;

  // x0 is hardwired to zero, so it can never create a real dependency.
  function automatic logic entry_match(input oitf_entry_t e, input logic [RIDX_W_DEF-1:0] idx);
    return e.vld & e.rdwen & (e.rdidx == idx) & (idx != '0);
  endfunction

endpackage

// File: rtl/disp_oitf.sv
// Outstanding instruction track FIFO: in-order allocate/retire of long-pipe ops
// with a combinational per-entry match vector for rs1, rs2 and rd queries.
module disp_oitf
  import disp_sched_pkg::*;
#(
  parameter int OITF_DEPTH = OITF_DEPTH_DEF,
  parameter int ITAG_W     = ITAG_W_DEF,
  parameter int RIDX_W     = RIDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_i,
  input  logic                  alloc_rdwen_i,
  input  logic [RIDX_W-1:0]     alloc_rdidx_i,
  input  logic                  ret_i,
  input  logic [ITAG_W-1:0]     ret_itag_i,
  input  logic [RIDX_W-1:0]     q_rs1_i,
  input  logic [RIDX_W-1:0]     q_rs2_i,
  input  logic [RIDX_W-1:0]     q_rd_i,
  output logic [OITF_DEPTH-1:0] match_rs1_o,
  output logic [OITF_DEPTH-1:0] match_rs2_o,
  output logic [OITF_DEPTH-1:0] match_rd_o,
  output logic [ITAG_W-1:0]     wptr_idx_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PTR_W = ITAG_W + 1;

  oitf_entry_t              entries_q [OITF_DEPTH];
  oitf_entry_t              entries_d [OITF_DEPTH];
  logic        [PTR_W-1:0]  wptr_q, wptr_d;
  logic        [PTR_W-1:0]  rptr_q, rptr_d;

  assign empty_o    = (rptr_q == wptr_q);
  assign full_o     = (rptr_q[ITAG_W-1:0] == wptr_q[ITAG_W-1:0]) &&
                      (rptr_q[ITAG_W] != wptr_q[ITAG_W]);
  assign wptr_idx_o = wptr_q[ITAG_W-1:0];

  // Alloc is never issued when full, so alloc and retire never touch the same slot.
  always_comb begin
    entries_d = entries_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (alloc_i) begin
      entries_d[wptr_q[ITAG_W-1:0]] = '{vld: 1'b1, rdwen: alloc_rdwen_i, rdidx: alloc_rdidx_i};
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (ret_i && !empty_o) begin
      entries_d[rptr_q[ITAG_W-1:0]].vld = 1'b0;
      rptr_d = rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OITF_DEPTH; i++) entries_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      entries_q <= entries_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_comb begin
    match_rs1_o = '0;
    match_rs2_o = '0;
    match_rd_o  = '0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      match_rs1_o[i] = entry_match(entries_q[i], q_rs1_i);
      match_rs2_o[i] = entry_match(entries_q[i], q_rs2_i);
      match_rd_o[i]  = entry_match(entries_q[i], q_rd_i);
    end
  end

  a_ret_not_empty: assert property (@(posedge clk) disable iff (rst) ret_i |-> !empty_o);
  a_ret_in_order:  assert property (@(posedge clk) disable iff (rst)
                     (ret_i && !empty_o) |-> (ret_itag_i == rptr_q[ITAG_W-1:0]));

endmodule

// File: rtl/disp_sched.sv
// Dispatch scheduler: routes decoded instructions to ALU or long pipe, stalling
// on OITF hazards, serial ops, a full OITF or flush.
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int OITF_DEPTH = OITF_DEPTH_DEF,
  parameter int ITAG_W     = ITAG_W_DEF,
  parameter int RIDX_W     = RIDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_vld,
  output logic              dec_rdy,
  input  logic              dec_rs1en,
  input  logic              dec_rs2en,
  input  logic [RIDX_W-1:0] dec_rs1_idx,
  input  logic [RIDX_W-1:0] dec_rs2_idx,
  input  logic              dec_rdwen,
  input  logic [RIDX_W-1:0] dec_rdidx,
  input  logic              dec_long,
  input  logic              dec_serial,
  output logic              disp2alu_vld,
  input  logic              disp2alu_rdy,
  output logic              disp2lng_vld,
  input  logic              disp2lng_rdy,
  output logic [ITAG_W-1:0] disp2lng_itag,
  input  logic              lng_ret_vld,
  input  logic [ITAG_W-1:0] lng_ret_itag,
  input  logic              flush,
  output logic              oitf_empty,
  output logic              oitf_full
);

  logic [OITF_DEPTH-1:0] match_rs1, match_rs2, match_rd;
  logic                  hazard;
  logic                  stall;
  logic                  alloc;

  disp_oitf #(
    .OITF_DEPTH (OITF_DEPTH),
    .ITAG_W     (ITAG_W),
    .RIDX_W     (RIDX_W)
  ) u_oitf (
    .clk           (clk),
    .rst           (rst),
    .alloc_i       (alloc),
    .alloc_rdwen_i (dec_rdwen),
    .alloc_rdidx_i (dec_rdidx),
    .ret_i         (lng_ret_vld),
    .ret_itag_i    (lng_ret_itag),
    .q_rs1_i       (dec_rs1_idx),
    .q_rs2_i       (dec_rs2_idx),
    .q_rd_i        (dec_rdidx),
    .match_rs1_o   (match_rs1),
    .match_rs2_o   (match_rs2),
    .match_rd_o    (match_rd),
    .wptr_idx_o    (disp2lng_itag),
    .empty_o       (oitf_empty),
    .full_o        (oitf_full)
  );

  // Stall uses only registered OITF state, so retirement never reaches dec_rdy combinationally.
  always_comb begin
    hazard = (dec_rs1en & (|match_rs1)) |
             (dec_rs2en & (|match_rs2)) |
             (dec_rdwen & (|match_rd));
    stall  = hazard | (dec_serial & ~oitf_empty) | (dec_long & oitf_full) | flush;

    disp2alu_vld = dec_vld & ~dec_long & ~stall;
    disp2lng_vld = dec_vld &  dec_long & ~stall;
    dec_rdy      = ~stall & (dec_long ? disp2lng_rdy : disp2alu_rdy);
    alloc        = disp2lng_vld & disp2lng_rdy;
  end

endmodule
